dcache_ctrl: RTL and testbench

Control stage for the 2-way, 16-set, 32-byte-line data cache, between the MEM stage of the pipeline and the cache tag/data SRAM plus the 256-bit data memory. Decodes CPU load/store requests, serves hits in zero extra cycles, and handles misses with a write-back / write-allocate FSM. While a miss is outstanding, it stalls the pipeline.

---
 rtl/dcache_pkg.sv | 31 +++
 rtl/dcache_word_merge.sv | 27 ++
 rtl/dcache_ctrl.sv | 146 ++++++++++++++
 tb/tb_dcache_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared parameters, address slices and FSM states for the data cache controller
package dcache_pkg;

   localparam int TAG_W     = 23;
   localparam int IDX_W     = 4;
   localparam int LINE_W    = 256;
   localparam int WSEL_W    = 3;
   localparam int VALID_BIT = 24;
   localparam int DIRTY_BIT = 23;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MISS,
      ST_WRITEBACK,
      ST_REFILL,
      ST_REFILL_DONE
   } state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
      return addr[31:9];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
      return addr[8:5];
   endfunction

   function automatic logic [WSEL_W-1:0] addr_word(input logic [31:0] addr);
      return addr[4:2];
   endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// rtl/dcache_word_merge.sv - word extract and word insert on one cache line
module dcache_word_merge
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] line_i,
   input  logic [WSEL_W-1:0] word_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic [LINE_W-1:0] line_o
);

   logic [7:0] bit_base;

   assign bit_base = {word_i, 5'b0};

   // Load path: pick the addressed 32-bit word out of the line.
   always_comb begin
      rdata_o = line_i[bit_base +: 32];
   end

   // Store path: same line with the addressed word replaced.
   always_comb begin
      line_o = line_i;
      line_o[bit_base +: 32] = wdata_i;
   end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - data cache control stage: hit service and write-back/write-allocate miss FSM
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_data_i,
   input  logic              cpu_MemRead_i,
   input  logic              cpu_MemWrite_i,
   output logic [31:0]       cpu_data_o,
   output logic              cpu_stall_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [IDX_W-1:0]  sram_idx_o,
   output logic [24:0]       sram_tag_o,
   output logic [LINE_W-1:0] sram_data_o,
   output logic              sram_enable_o,
   output logic              sram_write_o,
   input  logic [24:0]       sram_tag_i,
   input  logic [LINE_W-1:0] sram_data_i,
   input  logic              sram_hit_i
);

   state_t            state;
   state_t            state_nx;
   logic              req;
   logic              idle_live;
   logic              miss_start;
   logic              victim_dirty;
   logic [TAG_W-1:0]  tag;
   logic [IDX_W-1:0]  idx;
   logic [WSEL_W-1:0] word_sel;
   logic [31:0]       line_addr;
   logic [31:0]       victim_addr;
   logic [31:0]       rd_word;
   logic [LINE_W-1:0] merged_line;
   logic [1:0]        addr_unused;

   assign addr_unused  = cpu_addr_i[1:0];
   assign req          = cpu_MemRead_i | cpu_MemWrite_i;
   assign tag          = addr_tag(cpu_addr_i);
   assign idx          = addr_idx(cpu_addr_i);
   assign word_sel     = addr_word(cpu_addr_i);
   assign line_addr    = {cpu_addr_i[31:5], 5'b0};
   assign victim_addr  = {sram_tag_i[TAG_W-1:0], idx, 5'b0};
   assign victim_dirty = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];
   // Reset is asynchronous, so the combinational outputs are gated by it too.
   assign idle_live    = (state == ST_IDLE) & ~rst_i;
   assign miss_start   = idle_live & req & ~sram_hit_i;
   assign sram_idx_o   = idx;

   dcache_word_merge u_merge (
      .line_i  (sram_data_i),
      .word_i  (word_sel),
      .wdata_i (cpu_data_i),
      .rdata_o (rd_word),
      .line_o  (merged_line)
   );

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nx;
   end

   // Next-state: miss goes through optional write-back, then refill, then back to lookup.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:        if (miss_start) state_nx = ST_MISS;
         ST_MISS:        state_nx = mem_write_o ? ST_WRITEBACK : ST_REFILL;
         ST_WRITEBACK:   if (mem_ack_i) state_nx = ST_REFILL;
         ST_REFILL:      if (mem_ack_i) state_nx = ST_REFILL_DONE;
         ST_REFILL_DONE: state_nx = ST_IDLE;
         default:        state_nx = ST_IDLE;
      endcase
   end

   // Memory request registers: victim decision is captured when the miss is first seen.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (miss_start) begin
                  mem_enable_o <= 1'b1;
                  if (victim_dirty) begin
                     mem_write_o <= 1'b1;
                     mem_addr_o  <= victim_addr;
                     mem_data_o  <= sram_data_i;
                  end else begin
                     mem_write_o <= 1'b0;
                     mem_addr_o  <= line_addr;
                  end
               end
            end
            ST_WRITEBACK: begin
               if (mem_ack_i) begin
                  mem_write_o <= 1'b0;
                  mem_addr_o  <= line_addr;
               end
            end
            ST_REFILL: begin
               if (mem_ack_i) mem_enable_o <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Outputs to CPU and SRAM: hit service in IDLE, line install on refill completion.
   always_comb begin
      cpu_stall_o   = miss_start | (~rst_i & (state != ST_IDLE));
      cpu_data_o    = '0;
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
      sram_tag_o    = {2'b00, tag};
      sram_data_o   = sram_data_i;
      if (idle_live && req) begin
         sram_enable_o = 1'b1;
         if (sram_hit_i) begin
            cpu_data_o = rd_word;
            if (cpu_MemWrite_i) begin
               sram_write_o = 1'b1;
               sram_tag_o   = {2'b11, tag};
               sram_data_o  = merged_line;
            end
         end
      end else if (state == ST_REFILL && mem_ack_i && !rst_i) begin
         sram_enable_o = 1'b1;
         sram_write_o  = 1'b1;
         sram_tag_o    = {2'b10, tag};
         sram_data_o   = mem_data_i;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl with SRAM and memory models
module tb_dcache_ctrl;

   localparam int MEM_L = 10;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic [31:0]  cpu_addr_i = '0;
   logic [31:0]  cpu_data_i = '0;
   logic         cpu_MemRead_i = 1'b0;
   logic         cpu_MemWrite_i = 1'b0;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [255:0] mem_rdata = '0;
   logic         ack_r = 1'b0;
   logic         ack_force = 1'b0;
   logic [3:0]   sram_idx_o;
   logic [24:0]  sram_tag_o;
   logic [255:0] sram_data_o;
   logic         sram_enable_o;
   logic         sram_write_o;
   logic [24:0]  sram_tag_i;
   logic [255:0] sram_data_i;
   logic         sram_hit_i;

   int total = 0;
   int bad = 0;

   dcache_ctrl dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .cpu_addr_i     (cpu_addr_i),
      .cpu_data_i     (cpu_data_i),
      .cpu_MemRead_i  (cpu_MemRead_i),
      .cpu_MemWrite_i (cpu_MemWrite_i),
      .cpu_data_o     (cpu_data_o),
      .cpu_stall_o    (cpu_stall_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data_o     (mem_data_o),
      .mem_enable_o   (mem_enable_o),
      .mem_write_o    (mem_write_o),
      .mem_data_i     (mem_rdata),
      .mem_ack_i      (ack_r | ack_force),
      .sram_idx_o     (sram_idx_o),
      .sram_tag_o     (sram_tag_o),
      .sram_data_o    (sram_data_o),
      .sram_enable_o  (sram_enable_o),
      .sram_write_o   (sram_write_o),
      .sram_tag_i     (sram_tag_i),
      .sram_data_i    (sram_data_i),
      .sram_hit_i     (sram_hit_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [255:0] line_of(input logic [31:0] a);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'hA000_0000 + {a[31:5], 5'b0} + 32'(k);
      return l;
   endfunction

   function automatic logic [255:0] put_word(input logic [255:0] l, input int k, input logic [31:0] w);
      logic [255:0] r;
      r = l;
      r[32*k +: 32] = w;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory model: acks L cycles after a request first appears, logs every transaction.
   int cnt = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   logic [31:0]  wb_addr = '0;
   logic [255:0] wb_data = '0;
   logic [31:0]  rd_addr = '0;
   always @(posedge clk_i) begin
      if (rst_i) begin
         ack_r <= 1'b0;
         cnt   <= 0;
      end else if (ack_r) begin
         ack_r <= 1'b0;
         cnt   <= 0;
      end else if (mem_enable_o) begin
         if (cnt == MEM_L-1) begin
            ack_r <= 1'b1;
            if (mem_write_o) begin
               wr_cnt  <= wr_cnt + 1;
               wb_addr <= mem_addr_o;
               wb_data <= mem_data_o;
            end else begin
               rd_cnt    <= rd_cnt + 1;
               rd_addr   <= mem_addr_o;
               mem_rdata <= line_of(mem_addr_o);
            end
         end
         cnt <= cnt + 1;
      end else begin
         cnt <= 0;
      end
   end

   // SRAM model: 2 ways x 16 sets, LRU victim presented on a miss.
   logic        clr = 1'b1;
   logic [24:0]  m_tag  [0:1][0:15];
   logic [255:0] m_data [0:1][0:15];
   logic         m_lru  [0:15];
   logic         m_way;
   logic [3:0]   m_idx;
   int           sram_wr_cnt = 0;
   logic [24:0]  last_wtag = '0;

   always_comb begin
      m_idx      = cpu_addr_i[8:5];
      sram_hit_i = 1'b0;
      m_way      = m_lru[m_idx];
      for (int w = 0; w < 2; w++) begin
         if (m_tag[w][m_idx][24] && m_tag[w][m_idx][22:0] == cpu_addr_i[31:9]) begin
            sram_hit_i = 1'b1;
            m_way      = w[0];
         end
      end
      sram_tag_i  = m_tag[m_way][m_idx];
      sram_data_i = m_data[m_way][m_idx];
   end

   always @(posedge clk_i) begin
      if (clr) begin
         for (int s = 0; s < 16; s++) begin
            m_tag[0][s]  <= '0;
            m_tag[1][s]  <= '0;
            m_data[0][s] <= '0;
            m_data[1][s] <= '0;
            m_lru[s]     <= 1'b0;
         end
      end else if (sram_write_o) begin
         m_tag[m_way][sram_idx_o]  <= sram_tag_o;
         m_data[m_way][sram_idx_o] <= sram_data_o;
         m_lru[sram_idx_o]         <= ~m_way;
         last_wtag                 <= sram_tag_o;
         sram_wr_cnt               <= sram_wr_cnt + 1;
      end
   end

   // One CPU access; called just after a rising edge. Returns stall count and hit-cycle outputs.
   task automatic access(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr,
                         output int stalls, output logic [31:0] rdata, output logic swr,
                         output logic [24:0] stag, output logic [255:0] sdata);
      cpu_addr_i     = a;
      cpu_data_i     = d;
      cpu_MemRead_i  = rd;
      cpu_MemWrite_i = wr;
      stalls = 0;
      @(negedge clk_i);
      while (cpu_stall_o && stalls < 200) begin
         stalls++;
         @(negedge clk_i);
      end
      rdata = cpu_data_o;
      swr   = sram_write_o;
      stag  = sram_tag_o;
      sdata = sram_data_o;
      @(posedge clk_i);
      #1;
      cpu_MemRead_i  = 1'b0;
      cpu_MemWrite_i = 1'b0;
   endtask

   int           st;
   logic [31:0]  rdv;
   logic         swr;
   logic [24:0]  stag;
   logic [255:0] sdat;
   int           snap;

   initial begin
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_stall", cpu_stall_o, 0);
      chk("rst_cpu_data", cpu_data_o, 0);
      chk("rst_mem_en", mem_enable_o, 0);
      chk("rst_mem_wr", mem_write_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_data", mem_data_o, 0);
      chk("rst_sram_wr", sram_write_o, 0);
      chk("rst_sram_en", sram_enable_o, 0);
      clr = 1'b0;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Clean load miss
      access(32'h40, 32'h0, 1'b1, 1'b0, st, rdv, swr, stag, sdat);
      chk("a_stall", st, MEM_L + 3);
      chk("a_rd_cnt", rd_cnt, 1);
      chk("a_wr_cnt", wr_cnt, 0);
      chk("a_rd_addr", rd_addr, 32'h40);
      chk("a_fill_tag", last_wtag, {2'b10, 23'h0});
      chk("a_data", rdv, 32'hA000_0040);

      // Store hit
      access(32'h44, 32'hDEADBEEF, 1'b0, 1'b1, st, rdv, swr, stag, sdat);
      chk("b_stall", st, 0);
      chk("b_swr", swr, 1);
      chk("b_tag", stag, {2'b11, 23'h0});
      chk("b_line", sdat, put_word(line_of(32'h40), 1, 32'hDEADBEEF));

      // Ack pulse while idle
      snap = sram_wr_cnt;
      ack_force = 1'b1;
      @(posedge clk_i);
      #1;
      ack_force = 1'b0;
      @(posedge clk_i);
      #1;
      chk("f_ack_stall", cpu_stall_o, 0);
      chk("f_ack_en", mem_enable_o, 0);
      chk("f_ack_sram", sram_wr_cnt, snap);
      access(32'h40, 32'h0, 1'b1, 1'b0, st, rdv, swr, stag, sdat);
      chk("f_hit_stall", st, 0);
      chk("f_hit_data", rdv, 32'hA000_0040);

      // Read and write together behave as a store
      access(32'h48, 32'hCAFEF00D, 1'b1, 1'b1, st, rdv, swr, stag, sdat);
      chk("f_both_stall", st, 0);
      chk("f_both_swr", swr, 1);
      chk("f_both_tag", stag, {2'b11, 23'h0});
      access(32'h48, 32'h0, 1'b1, 1'b0, st, rdv, swr, stag, sdat);
      chk("f_both_rd", rdv, 32'hCAFEF00D);
      access(32'h44, 32'h0, 1'b1, 1'b0, st, rdv, swr, stag, sdat);
      chk("b_rd_back", rdv, 32'hDEADBEEF);

      // Dirty victim: set 5 gets tag 1 (dirtied) and tag 3, then tag 2 evicts tag 1
      access(32'h2A0, 32'h0, 1'b1, 1'b0, st, rdv, swr, stag, sdat);
      access(32'h2A0, 32'h11111111, 1'b0, 1'b1, st, rdv, swr, stag, sdat);
      access(32'h6A0, 32'h0, 1'b1, 1'b0, st, rdv, swr, stag, sdat);
      chk("c_fill2_stall", st, MEM_L + 3);
      snap = wr_cnt;
      access(32'h4A0, 32'h0, 1'b1, 1'b0, st, rdv, swr, stag, sdat);
      chk("c_stall", st, 2*MEM_L + 4);
      chk("c_wb_cnt", wr_cnt, snap + 1);
      chk("c_wb_addr", wb_addr, 32'h2A0);
      chk("c_wb_data", wb_data, put_word(line_of(32'h2A0), 0, 32'h11111111));
      chk("c_rd_addr", rd_addr, 32'h4A0);
      chk("c_data", rdv, 32'hA000_04A0);

      // Store miss to a clean set: write-allocate
      access(32'hEC, 32'h12345678, 1'b0, 1'b1, st, rdv, swr, stag, sdat);
      chk("d_stall", st, MEM_L + 3);
      chk("d_swr", swr, 1);
      chk("d_tag", stag, {2'b11, 23'h0});
      chk("d_line", sdat, put_word(line_of(32'hE0), 3, 32'h12345678));
      access(32'hEC, 32'h0, 1'b1, 1'b0, st, rdv, swr, stag, sdat);
      chk("d_rd_stall", st, 0);
      chk("d_rd", rdv, 32'h12345678);

      // Reset during refill
      snap = sram_wr_cnt;
      cpu_addr_i    = 32'h100;
      cpu_MemRead_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      chk("e_pre_en", mem_enable_o, 1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("e_rst_en", mem_enable_o, 0);
      chk("e_rst_stall", cpu_stall_o, 0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      cpu_MemRead_i = 1'b0;
      ack_force = 1'b1;
      @(posedge clk_i);
      #1;
      ack_force = 1'b0;
      chk("e_sram_untouched", sram_wr_cnt, snap);
      chk("e_idle_stall", cpu_stall_o, 0);
      chk("e_idle_en", mem_enable_o, 0);
      access(32'h100, 32'h0, 1'b1, 1'b0, st, rdv, swr, stag, sdat);
      chk("e_remiss_stall", st, MEM_L + 3);
      chk("e_rd_addr", rd_addr, 32'h100);
      chk("e_data", rdv, 32'hA000_0100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
